kernel_pr_start_arbiter: RTL

KERNEL_PR_START_ARBITER -- requirements
Module: kernel_pr_start_arbiter

---
 rtl/kernel_pr_start_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/kernel_pr_start_arbiter.sv
// rtl/kernel_pr_start_arbiter.sv - round-robin kernel start-token arbiter with outstanding-token limit and flush drain
// Optional grant statistics output enabled by KERNEL_PR_START_ARB_STATS_EN.
module kernel_pr_start_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int MAX_OUT   = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 fifo_write,
    output logic [ID_WIDTH-1:0]  fifo_din,
    input  logic                 fifo_full_n,
    input  logic                 done,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic [CNT_WIDTH-1:0] outstanding,
`ifdef KERNEL_PR_START_ARB_STATS_EN
    output logic [15:0]          grant_total,
`endif
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ID_WIDTH-1:0]    r_rr_ptr;
    logic [CNT_WIDTH-1:0]   r_outstanding;
    logic                   r_err;
    logic                   r_flush_done;

    logic                   w_can_grant;
    logic                   w_found;
    logic                   w_grant;
    logic [ID_WIDTH-1:0]    w_gnt_id;
    logic [ID_WIDTH-1:0]    w_next_ptr;
    logic [2*NUM_REQ-1:0]   w_rot;

    // Limit check uses the registered count, so a done in a full cycle frees a slot only next cycle.
    assign w_can_grant = reset && (r_state == S_RUN) && !flush_req && fifo_full_n
                         && (r_outstanding < CNT_WIDTH'(MAX_OUT));

    // Rotating the doubled request vector puts rr_ptr at bit 0, so the search is a plain priority scan.
    assign w_rot = {req_valid, req_valid} >> r_rr_ptr;

    always_comb begin
        int sum;
        w_found  = 1'b0;
        w_gnt_id = '0;
        sum      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                sum     = int'(r_rr_ptr) + i;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                w_gnt_id = ID_WIDTH'(sum);
            end
        end
    end

    assign w_grant    = w_can_grant && w_found;
    assign w_next_ptr = (int'(w_gnt_id) == NUM_REQ - 1) ? '0 : (w_gnt_id + ID_WIDTH'(1));

    assign req_ready   = w_grant ? (NUM_REQ'(1) << w_gnt_id) : '0;
    assign fifo_write  = w_grant;
    assign fifo_din    = w_grant ? w_gnt_id : '0;
    assign flush_done  = r_flush_done;
    assign outstanding = r_outstanding;
    assign err         = r_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_flush_done  <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;

            if (w_grant) begin
                r_rr_ptr <= w_next_ptr;
            end

            case ({w_grant, done})
                2'b10: r_outstanding <= r_outstanding + CNT_WIDTH'(1);
                2'b01: begin
                    if (r_outstanding != '0) begin
                        r_outstanding <= r_outstanding - CNT_WIDTH'(1);
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: r_outstanding <= r_outstanding;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (flush_req) begin
                        r_state <= S_DRAIN;
                    end else if (|req_valid) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush_req) begin
                        r_state <= S_DRAIN;
                    end else if (!(|req_valid)) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state      <= S_IDLE;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef KERNEL_PR_START_ARB_STATS_EN
    logic [15:0] r_grant_total;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant_total <= '0;
        end else if (w_grant && (r_grant_total != 16'hFFFF)) begin
            r_grant_total <= r_grant_total + 16'd1;
        end
    end

    assign grant_total = r_grant_total;
`endif

endmodule
